// File: rtl/tri_pkg.sv
// Shared constants and types for the triangle raster capture stage.
package tri_pkg;
    localparam int COORD_W = 3;
    localparam int GRID    = 8;
    localparam int CNT_W   = 7;

    // An empty box is inverted (min=7, max=0) so the first point overwrites both ends.
    localparam logic [COORD_W-1:0] BBOX_MIN_RST = 3'd7;
    localparam logic [COORD_W-1:0] BBOX_MAX_RST = 3'd0;

    typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} cap_state_t;
endpackage

// File: rtl/tri_bbox_tracker.sv
// Bounding box of the points captured in the current frame.
module tri_bbox_tracker
    import tri_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               upd,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] xmin,
    output logic [COORD_W-1:0] xmax,
    output logic [COORD_W-1:0] ymin,
    output logic [COORD_W-1:0] ymax
);
    logic [COORD_W-1:0] xmin_base, xmax_base, ymin_base, ymax_base;
    logic [COORD_W-1:0] xmin_nxt, xmax_nxt, ymin_nxt, ymax_nxt;

    // A clear and an update in the same cycle update from the cleared box.
    always_comb begin
        xmin_base = clear ? BBOX_MIN_RST : xmin;
        xmax_base = clear ? BBOX_MAX_RST : xmax;
        ymin_base = clear ? BBOX_MIN_RST : ymin;
        ymax_base = clear ? BBOX_MAX_RST : ymax;
        xmin_nxt  = (upd && x < xmin_base) ? x : xmin_base;
        xmax_nxt  = (upd && x > xmax_base) ? x : xmax_base;
        ymin_nxt  = (upd && y < ymin_base) ? y : ymin_base;
        ymax_nxt  = (upd && y > ymax_base) ? y : ymax_base;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xmin <= BBOX_MIN_RST;
            xmax <= BBOX_MAX_RST;
            ymin <= BBOX_MIN_RST;
            ymax <= BBOX_MAX_RST;
        end else begin
            xmin <= xmin_nxt;
            xmax <= xmax_nxt;
            ymin <= ymin_nxt;
            ymax <= ymax_nxt;
        end
    end
endmodule

// File: rtl/tri_raster_capture.sv
// Captures the rasterizer point stream into an 8x8 bitmap and scans it out row by row.
module tri_raster_capture
    import tri_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               busy_in,
    input  logic               po_in,
    input  logic [COORD_W-1:0] xo_in,
    input  logic [COORD_W-1:0] yo_in,
    output logic               ready,
    output logic               row_valid,
    input  logic               row_ready,
    output logic [COORD_W-1:0] row_idx,
    output logic [GRID-1:0]    row_data,
    output logic [CNT_W-1:0]   pix_cnt,
    output logic [COORD_W-1:0] xmin,
    output logic [COORD_W-1:0] xmax,
    output logic [COORD_W-1:0] ymin,
    output logic [COORD_W-1:0] ymax,
    output logic               done,
    output logic               err
);
    cap_state_t state, state_nxt;

    logic                      busy_q;
    logic                      rise, fall;
    logic                      clear, capture, err_set;
    logic [GRID-1:0][GRID-1:0] bitmap;   // bitmap[y][x]

    assign rise = busy_in & ~busy_q;
    assign fall = ~busy_in & busy_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        row_valid = 1'b0;
        done      = 1'b0;
        clear     = 1'b0;
        capture   = 1'b0;
        err_set   = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (rise) begin
                    clear     = 1'b1;
                    capture   = po_in;
                    state_nxt = ACCUM;
                end else begin
                    err_set   = po_in;
                end
            end
            ACCUM: begin
                capture = po_in;
                if (fall) state_nxt = SCAN;
            end
            SCAN: begin
                row_valid = 1'b1;
                err_set   = po_in | rise;
                if (row_ready && row_idx == COORD_W'(GRID - 1)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                err_set   = po_in | rise;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= 1'b0;
            bitmap  <= '0;
            pix_cnt <= '0;
            err     <= 1'b0;
            row_idx <= '0;
        end else begin
            busy_q <= busy_in;
            if (err_set) err <= 1'b1;
            // The per-bit set follows the clear so a rise-cycle point survives it.
            if (clear) bitmap <= '0;
            if (capture) bitmap[yo_in][xo_in] <= 1'b1;
            if (clear)
                pix_cnt <= capture ? CNT_W'(1) : '0;
            else if (capture && !bitmap[yo_in][xo_in])
                pix_cnt <= pix_cnt + CNT_W'(1);
            if (state == SCAN && row_ready) row_idx <= row_idx + COORD_W'(1);
            else if (state == DONE)         row_idx <= '0;
        end
    end

    assign row_data = row_valid ? bitmap[row_idx] : '0;

    tri_bbox_tracker u_bbox (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .upd   (capture),
        .x     (xo_in),
        .y     (yo_in),
        .xmin  (xmin),
        .xmax  (xmax),
        .ymin  (ymin),
        .ymax  (ymax)
    );
endmodule

// File: tb/tb_tri_raster_capture.sv
// Directed bench for tri_raster_capture: frame capture, dedup, backpressure, errors, reset.
module tb_tri_raster_capture;
    logic       clk = 1'b0;
    logic       reset, busy_in, po_in, row_ready;
    logic [2:0] xo_in, yo_in;
    logic       ready, row_valid, done, err;
    logic [2:0] row_idx, xmin, xmax, ymin, ymax;
    logic [7:0] row_data;
    logic [6:0] pix_cnt;

    int vectors = 0;
    int errors  = 0;

    tri_raster_capture dut (
        .clk       (clk),
        .reset     (reset),
        .busy_in   (busy_in),
        .po_in     (po_in),
        .xo_in     (xo_in),
        .yo_in     (yo_in),
        .ready     (ready),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_idx   (row_idx),
        .row_data  (row_data),
        .pix_cnt   (pix_cnt),
        .xmin      (xmin),
        .xmax      (xmax),
        .ymin      (ymin),
        .ymax      (ymax),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bbox(input logic [2:0] x0, input logic [2:0] x1,
                            input logic [2:0] y0, input logic [2:0] y1);
        chk("xmin", 32'(xmin), 32'(x0));
        chk("xmax", 32'(xmax), 32'(x1));
        chk("ymin", 32'(ymin), 32'(y0));
        chk("ymax", 32'(ymax), 32'(y1));
    endtask

    // Walks all eight rows (state must already be SCAN showing row 0), optionally
    // stalling three cycles on one row, then checks the done pulse.
    task automatic scan(input logic [63:0] rows, input int stall_at);
        logic [7:0] e;
        for (int r = 0; r < 8; r++) begin
            e = rows[r*8 +: 8];
            if (r == stall_at) begin
                row_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk("stall_idx", 32'(row_idx), 32'(r));
                    chk("stall_data", 32'(row_data), 32'(e));
                    chk("stall_done", 32'(done), 32'd0);
                end
                row_ready = 1'b1;
            end
            chk("row_valid", 32'(row_valid), 32'd1);
            chk("row_idx", 32'(row_idx), 32'(r));
            chk("row_data", 32'(row_data), 32'(e));
            tick();
        end
        chk("done_hi", 32'(done), 32'd1);
        chk("done_rv", 32'(row_valid), 32'd0);
        chk("done_idx", 32'(row_idx), 32'd0);
        tick();
        chk("done_lo", 32'(done), 32'd0);
        chk("idle_ready", 32'(ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; busy_in = 1'b0; po_in = 1'b0; row_ready = 1'b1;
        xo_in = '0; yo_in = '0;
        tick(); tick();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_rv", 32'(row_valid), 32'd0);
        chk("rst_idx", 32'(row_idx), 32'd0);
        chk("rst_data", 32'(row_data), 32'd0);
        chk("rst_cnt", 32'(pix_cnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk_bbox(3'd7, 3'd0, 3'd7, 3'd0);
        reset = 1'b0;
        tick();

        // Frame 1: (1,1) in the rise cycle, (2,1), (1,2); stall at row 2.
        busy_in = 1'b1; po_in = 1'b1; xo_in = 3'd1; yo_in = 3'd1;
        tick();
        chk("f1_ready", 32'(ready), 32'd0);
        chk("f1_cnt1", 32'(pix_cnt), 32'd1);
        xo_in = 3'd2; yo_in = 3'd1; tick();
        xo_in = 3'd1; yo_in = 3'd2; tick();
        po_in = 1'b0; busy_in = 1'b0; tick();
        chk("f1_cnt", 32'(pix_cnt), 32'd3);
        chk_bbox(3'd1, 3'd2, 3'd1, 3'd2);
        scan(64'h0000_0000_0002_0600, 2);
        chk("f1_cnt_hold", 32'(pix_cnt), 32'd3);

        // Frame 2: duplicate (3,3).
        busy_in = 1'b1; tick();
        po_in = 1'b1; xo_in = 3'd3; yo_in = 3'd3; tick(); tick();
        po_in = 1'b0; busy_in = 1'b0; tick();
        chk("dup_cnt", 32'(pix_cnt), 32'd1);
        chk_bbox(3'd3, 3'd3, 3'd3, 3'd3);
        scan(64'h0000_0000_0800_0000, -1);
        chk("dup_cnt_hold", 32'(pix_cnt), 32'd1);

        // Frame 3: empty, busy high four cycles.
        busy_in = 1'b1; tick();
        chk("empty_clr_cnt", 32'(pix_cnt), 32'd0);
        chk("empty_clr_xmin", 32'(xmin), 32'd7);
        tick(); tick(); tick();
        busy_in = 1'b0; tick();
        chk("empty_cnt", 32'(pix_cnt), 32'd0);
        chk_bbox(3'd7, 3'd0, 3'd7, 3'd0);
        scan(64'h0, -1);

        // Frame 4: (2,5), then a stray point at (5,5) during scan.
        busy_in = 1'b1; po_in = 1'b1; xo_in = 3'd2; yo_in = 3'd5; tick();
        po_in = 1'b0; busy_in = 1'b0; tick();
        chk("err_pre", 32'(err), 32'd0);
        row_ready = 1'b0; po_in = 1'b1; xo_in = 3'd5; yo_in = 3'd5; tick();
        po_in = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        chk("err_cnt", 32'(pix_cnt), 32'd1);
        chk("err_idx", 32'(row_idx), 32'd0);
        row_ready = 1'b1;
        scan(64'h0000_0400_0000_0000, -1);
        chk("err_sticky", 32'(err), 32'd1);
        chk_bbox(3'd2, 3'd2, 3'd5, 3'd5);

        // Frame 5: (0,4), reset while row 4 is presented.
        busy_in = 1'b1; po_in = 1'b1; xo_in = 3'd0; yo_in = 3'd4; tick();
        po_in = 1'b0; busy_in = 1'b0; tick();
        tick(); tick(); tick(); tick();
        chk("pre_rst_idx", 32'(row_idx), 32'd4);
        chk("pre_rst_data", 32'(row_data), 32'h01);
        reset = 1'b1; tick();
        chk("mid_rst_rv", 32'(row_valid), 32'd0);
        chk("mid_rst_idx", 32'(row_idx), 32'd0);
        chk("mid_rst_cnt", 32'(pix_cnt), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        reset = 1'b0; tick();
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_rv", 32'(row_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/tri_raster_capture.md
# tri_raster_capture

Downstream stage of the triangle rasterizer. Consumes the rasterizer's point stream (`po`/`xo`/`yo`), framed by its `busy` signal, into an 8x8 occupancy bitmap. It tracks unique-pixel count and bounding box per frame. When the frame ends it scans the bitmap out row by row over a valid/ready handshake for display or compare logic.

## Interface
- Parameters: none. Grid is fixed 8x8 with 3-bit coordinates (package constants).
- `clk`  in  1  clock; reset is synchronous, active-high.
- `reset`  in  1  synchronous, active-high; clears all state.
- `busy_in`  in  1  rasterizer busy; high marks an active frame.
- `po_in`  in  1  point valid.
- `xo_in`  in  3  point x.
- `yo_in`  in  3  point y.
- `ready`  out  1  high in IDLE only.
- `row_valid`  out  1  scan-out row valid.
- `row_ready`  in  1  consumer accepts row.
- `row_idx`  out  3  row number (y).
- `row_data`  out  8  `row_data[x]` = pixel (x, row_idx) set.
- `pix_cnt`  out  7  unique pixels in frame, 0..64.
- `xmin`, `xmax`, `ymin`, `ymax`  out  3 each  bounding box; meaningful only when `pix_cnt`≠0.
- `done`  out  1  one-cycle pulse after last row accepted.
- `err`  out  1  sticky; a point or frame start arrived outside ACCUM/IDLE.

## Operation
- The block registers `busy_in` each cycle into `busy_q`.
  - Rise = `busy_in & ~busy_q`.
  - Fall = `~busy_in & busy_q`.
- States: IDLE, ACCUM, SCAN, DONE.
- IDLE:
  - Bitmap and stats from the previous frame are retained.
  - On rise: clear bitmap, set `pix_cnt`=0, xmin/ymin=7, xmax/ymax=0, then go to ACCUM.
  - A `po_in` in the rise cycle is applied on top of the cleared state.
- ACCUM, on `po_in`:
  - Set bit (x,y).
  - Increment `pix_cnt` only if the bit was previously 0.
  - Update min/max with the point.
  - On fall, go to SCAN; a `po_in` in the fall cycle is still captured.
- SCAN:
  - `row_valid`=1, starting at `row_idx`=0.
  - On `row_valid & row_ready`, increment `row_idx`.
  - Acceptance of row 7 goes to DONE.
- DONE:
  - `done`=1 for one cycle, `row_valid`=0, `row_idx` returns to 0, then IDLE.
- Errors:
  - `po_in` or rise while in SCAN/DONE sets `err` and is dropped; bitmap and stats are unchanged.
  - `err` clears only on reset.
- Fall while in IDLE is ignored.
- Points in IDLE without a preceding rise set `err` and are dropped.
- Reset mid-operation: next cycle state is IDLE with all outputs at reset values; any frame in progress is lost.

## Timing
- Reset values:
  - `ready`=1.
  - `row_valid`=0, `row_idx`=0, `row_data`=0.
  - `pix_cnt`=0, xmin=ymin=7, xmax=ymax=0.
  - `done`=0, `err`=0.
- Point capture latency: bitmap, count and bbox are updated at the clock edge where `po_in`=1. They are visible the following cycle.
- The first row is valid the cycle after the fall edge is sampled (1 cycle after `busy_in` low is seen).
- `row_data` and `row_idx` are held stable while `row_valid & ~row_ready`.
- With `row_ready` held high, scan takes exactly 8 cycles. `done` follows in the cycle after row 7 is accepted.
- Stats are stable from the cycle after fall until the next rise.

## Structure
- Package `tri_pkg`:
  - `COORD_W`=3, `GRID`=8, `CNT_W`=7.
  - State enum `cap_state_t` {IDLE, ACCUM, SCAN, DONE}.
  - `BBOX_RST` constants.
- Sub-module `tri_bbox_tracker`:
  - Holds min/max registers.
  - Ports: `clear`, `upd`, x, y.
- Bitmap, count and FSM live in the top.

## Test plan
- Frame with points (1,1),(2,1),(1,2), `row_ready`=1 -> rows 0..7 = 00,06,02,00,00,00,00,00. `pix_cnt`=3, bbox x1..2 y1..2, `done` pulses once.
- Duplicate point (3,3) sent twice in one frame -> `pix_cnt`=1, row 3 = 0x08.
- Backpressure: drop `row_ready` for 3 cycles while `row_idx`=2 -> `row_idx`/`row_data` held, no skip. Total scan is 11 cycles.
- Empty frame (`busy_in` high 4 cycles, no `po_in`) -> eight rows 0x00, `pix_cnt`=0, bbox 7/0 reset values, `done` pulses.
- `po_in` at (5,5) during SCAN -> `err`=1 and stays 1; row 5 unaffected; `pix_cnt` unchanged.
- Reset asserted mid-SCAN at row 4 -> next cycle `row_valid`=0, `row_idx`=0, `pix_cnt`=0, `ready`=1, no `done`.
